// File: rtl/equal_bist.sv
// -----------------------------------------------------------------------------
// equal_bist -- built-in self-test sequencer for an external 6-bit equality
// comparator. A 12-bit LFSR generates operand pairs. Each vector is driven,
// allowed to settle, and the comparator's answer is checked against the ideal
// result. Mismatches are counted, and the first failing pair is captured.
//
// Parameters
//   SETTLE  settle cycles between driving operands and sampling (1-15)
//   SEED    nonzero LFSR start value
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle run request, accepted only in IDLE
//   num_vectors  vectors per run, sampled on an accepted start (0 = 256)
//   dut_a/dut_b  operands driven to the comparator under test
//   dut_out      comparator result (1 = equal)
//   busy         high while a run is in progress (not in the done cycle)
//   done         one-cycle pulse at the end of a run
//   pass         last completed run had no errors; held until the next start
//   err_count    mismatches in the current or last run, saturating at 255
//   fail_a/b     operands of the first failing vector (0 if none)
//
// Configuration
//   EQUAL_BIST_FORCE_EQ_EN  when defined, odd-indexed vectors drive
//                           dut_b = dut_a so the "equal" path is exercised.
// -----------------------------------------------------------------------------
module equal_bist #(
   parameter int unsigned SETTLE = 1,
   parameter logic [11:0] SEED   = 12'hACE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] num_vectors,
   output logic [5:0] dut_a,
   output logic [5:0] dut_b,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [5:0] fail_a,
   output logic [5:0] fail_b
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE_W,
      CHECK,
      FINISH
   } state_e;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_e      state_q, state_d;
   logic [11:0] lfsr_q, lfsr_d;
   logic [5:0]  dut_a_q, dut_a_d, dut_b_q, dut_b_d;
   logic [5:0]  fail_a_q, fail_a_d, fail_b_q, fail_b_d;
   logic [7:0]  err_q, err_d;
   logic        pass_q, pass_d;
   logic [8:0]  n_q, n_d;       // vectors in this run, 1..256
   logic [8:0]  idx_q, idx_d;   // index of the vector being processed
   logic [3:0]  settle_q, settle_d;

   logic        mismatch;
   logic [11:0] lfsr_next;
   logic [5:0]  next_b;

   // Fibonacci LFSR for x^12+x^11+x^10+x^4+1: taps at bits 11,10,9,3,
   // shifting left with the feedback bit entering at bit 0.
   assign lfsr_next = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};

   // Comparator answer disagrees with the ideal equality result.
   assign mismatch = dut_out != (dut_a_q == dut_b_q);

`ifdef EQUAL_BIST_FORCE_EQ_EN
   assign next_b = idx_q[0] ? lfsr_q[11:6] : lfsr_q[5:0];
`else
   assign next_b = lfsr_q[5:0];
`endif

   // NOTE: every signal written here gets its default first so that no path
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      dut_a_d  = dut_a_q;
      dut_b_d  = dut_b_q;
      fail_a_d = fail_a_q;
      fail_b_d = fail_b_q;
      err_d    = err_q;
      pass_d   = pass_q;
      n_d      = n_q;
      idx_d    = idx_q;
      settle_d = settle_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = DRIVE;
               lfsr_d   = SEED;
               err_d    = 8'd0;
               fail_a_d = 6'd0;
               fail_b_d = 6'd0;
               pass_d   = 1'b0;
               idx_d    = 9'd0;
               n_d      = (num_vectors == 8'd0) ? 9'd256 : {1'b0, num_vectors};
            end
         end
         DRIVE: begin
            dut_a_d  = lfsr_q[11:6];
            dut_b_d  = next_b;
            settle_d = SETTLE_LAST;
            state_d  = SETTLE_W;
         end
         SETTLE_W: begin
            if (settle_q == 4'd0) state_d = CHECK;
            else                  settle_d = settle_q - 4'd1;
         end
         CHECK: begin
            if (mismatch) begin
               if (err_q != 8'd255) err_d = err_q + 8'd1;
               // err_count only reaches zero again on a new start, so this
               // captures the first failing pair only.
               if (err_q == 8'd0) begin
                  fail_a_d = dut_a_q;
                  fail_b_d = dut_b_q;
               end
            end
            lfsr_d = lfsr_next;
            idx_d  = idx_q + 9'd1;
            if (idx_q + 9'd1 == n_q) begin
               state_d = FINISH;
               // Resolved here so pass is already valid in the done cycle,
               // including the final vector's result.
               pass_d  = (err_d == 8'd0);
            end else begin
               state_d = DRIVE;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         dut_a_q  <= 6'd0;
         dut_b_q  <= 6'd0;
         fail_a_q <= 6'd0;
         fail_b_q <= 6'd0;
         err_q    <= 8'd0;
         pass_q   <= 1'b0;
         n_q      <= 9'd0;
         idx_q    <= 9'd0;
         settle_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         dut_a_q  <= dut_a_d;
         dut_b_q  <= dut_b_d;
         fail_a_q <= fail_a_d;
         fail_b_q <= fail_b_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
      end
   end

   assign busy      = (state_q == DRIVE) || (state_q == SETTLE_W) || (state_q == CHECK);
   assign done      = (state_q == FINISH);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign dut_a     = dut_a_q;
   assign dut_b     = dut_b_q;

endmodule

// File: doc/equal_bist.md
EQUAL_BIST -- requirements
Module: equal_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of cycles (1-15) between driving operands and sampling dut_out.
REQ-002 The block SHALL have parameter SEED, default 12'hACE, giving the LFSR start value (nonzero).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle run request, honoured only in IDLE.
REQ-007 num_vectors  in  8  vectors per run, sampled on accepted start; 0 means 256.
REQ-008 dut_a  out  6  operand A driven to the external 6-bit equality comparator.
REQ-009 dut_b  out  6  operand B driven to the comparator.
REQ-010 dut_out  in  1  comparator result (1 = equal).
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse at end of run.
REQ-013 pass  out  1  high when the last completed run had zero errors; held until next accepted start.
REQ-014 err_count  out  8  mismatches in the current or last run, saturating at 255.
REQ-015 fail_a, fail_b  out  6 each  operands of the first failing vector; 0 if none.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SETTLE_W, CHECK and FINISH.
REQ-017 IDLE->DRIVE on start; this clears err_count, fail_a, fail_b and pass, loads LFSR with SEED and latches num_vectors.
REQ-018 DRIVE SHALL register dut_a=lfsr[11:6] and dut_b=lfsr[5:0] for one cycle, then go to SETTLE_W.
REQ-019 SETTLE_W SHALL last exactly SETTLE cycles with dut_a/dut_b stable, then go to CHECK.
REQ-020 CHECK SHALL sample dut_out, compare it with expected (dut_a==dut_b), and advance the LFSR one step.
REQ-021 The LFSR is 12-bit Fibonacci, polynomial x^12+x^11+x^10+x^4+1, shifting left with feedback into bit 0.
REQ-022 On mismatch, err_count SHALL increment unless it is 255. On the first mismatch only, fail_a and fail_b SHALL capture dut_a and dut_b.
REQ-023 From CHECK, the FSM SHALL go to DRIVE if vectors remain, else to FINISH.
REQ-024 FINISH SHALL pulse done, set pass=(err_count==0) including the final vector's result, deassert busy in the same cycle, and return to IDLE.
REQ-025 start while busy or in FINISH SHALL be ignored.
REQ-026 A run SHALL take exactly N*(SETTLE+2)+1 cycles from the cycle after start to the done cycle, where N is the vector count.
REQ-027 dut_a and dut_b SHALL hold their last values in IDLE.

Reset
REQ-028 While rst_n=0, the block SHALL go to IDLE with busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, dut_a=0, dut_b=0, lfsr=SEED and vector counter=0.
REQ-029 Reset mid-run SHALL abandon the run with no done pulse; the block SHALL then wait in IDLE for a new start.

Configuration
REQ-030 With EQUAL_BIST_FORCE_EQ_EN defined, every odd-indexed vector (1, 3, 5, ...) SHALL drive dut_b=dut_a. The LFSR SHALL still advance every CHECK.
REQ-031 With EQUAL_BIST_FORCE_EQ_EN undefined, every vector SHALL use the raw LFSR fields.

Verification
REQ-032 Reset, ideal comparator model, start with num_vectors=1 -> dut_a=43, dut_b=14; done at cycle 4 after start (SETTLE=1); pass=1; err_count=0.
REQ-033 Ideal comparator, num_vectors=0 -> exactly 256 CHECKs; done at cycle 769; pass=1.
REQ-034 Comparator stuck at 0, macro defined, num_vectors=4 -> err_count=2; fail_a=fail_b equal to vector-1 operands; pass=0.
REQ-035 Comparator stuck at 1, num_vectors=0, macro undefined -> err_count saturates at 255 when mismatches exceed 255; pass=0.
REQ-036 Pulse start during busy, then assert rst_n=0 mid-run -> extra start is ignored; after reset all outputs are 0, no done pulse, and a new run behaves as in REQ-032.
